// File: rtl/instr_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_register_pkg
// Description : Shared opcode/state encodings and width helpers for the
//               instruction register execute block.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_register_pkg;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        DIVIDE = 2'd2
    } state_t;

    localparam int c_DEPTH_DEF   = 32;
    localparam int c_OP_W_DEF    = 32;
    localparam int c_DIV_LAT_DEF = 4;

    function automatic int res_width(input int op_w);
        return 2 * op_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_register_alu.sv
`default_nettype none
// ============================================================================
// Module      : instr_register_alu
// Description : Combinational single-cycle ops (ZERO..MULT), sign-extended
//               to the full result width.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_register_alu
    import instr_register_pkg::*;
#(
    parameter int OP_W  = c_OP_W_DEF,
    parameter int RES_W = res_width(c_OP_W_DEF)
) (
    input  opcode_t                  i_opc,
    input  logic signed [OP_W-1:0]   i_a,
    input  logic signed [OP_W-1:0]   i_b,
    output logic signed [RES_W-1:0]  o_res
);

    logic signed [RES_W-1:0] w_a_ext;
    logic signed [RES_W-1:0] w_b_ext;

    assign w_a_ext = i_a;
    assign w_b_ext = i_b;

    always_comb begin
        o_res = '0;
        case (i_opc)
            ZERO:    o_res = '0;
            PASSA:   o_res = w_a_ext;
            PASSB:   o_res = w_b_ext;
            ADD:     o_res = w_a_ext + w_b_ext;
            SUB:     o_res = w_a_ext - w_b_ext;
            MULT:    o_res = w_a_ext * w_b_ext;
            default: o_res = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_register_exec.sv
`default_nettype none
// ============================================================================
// Module      : instr_register_exec
// Description : Instruction register with execute stage; single-cycle ops
//               pipeline back-to-back, DIV/MOD stall for DIV_LAT cycles.
//               Optional INSTR_REG_STATS_EN adds accept/div-by-zero counters.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_register_exec
    import instr_register_pkg::*;
#(
    parameter int DEPTH   = c_DEPTH_DEF,
    parameter int OP_W    = c_OP_W_DEF,
    parameter int DIV_LAT = c_DIV_LAT_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_en,
    output logic                          load_ready,
    input  opcode_t                       opcode,
    input  logic signed [OP_W-1:0]        operand_a,
    input  logic signed [OP_W-1:0]        operand_b,
    input  logic [$clog2(DEPTH)-1:0]      write_pointer,
    input  logic [$clog2(DEPTH)-1:0]      read_pointer,
`ifdef INSTR_REG_STATS_EN
    output logic [15:0]                   accept_count,
    output logic [7:0]                    div_zero_count,
`endif
    output logic [3+2*OP_W+res_width(OP_W)+1:0] instruction_word
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_RES_W = res_width(OP_W);
    localparam int c_CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    typedef struct packed {
        opcode_t                  opc;
        logic signed [OP_W-1:0]   op_a;
        logic signed [OP_W-1:0]   op_b;
        logic signed [c_RES_W-1:0] res;
        logic                     valid;
        logic                     err;
    } entry_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    opcode_t                   r_opc;
    logic signed [OP_W-1:0]    r_a;
    logic signed [OP_W-1:0]    r_b;
    logic [c_AW-1:0]           r_ptr;
    logic [c_CNT_W-1:0]        r_cnt;
    entry_t                    r_mem [DEPTH];

    logic                      w_accept;
    logic                      w_is_div;
    logic                      w_wb_en;
    entry_t                    w_wb_entry;
    logic signed [c_RES_W-1:0] w_alu_res;
    logic signed [c_RES_W-1:0] w_a_ext;
    logic signed [c_RES_W-1:0] w_b_ext;
    logic signed [c_RES_W-1:0] w_b_safe;
    logic signed [c_RES_W-1:0] w_quot;
    logic signed [c_RES_W-1:0] w_rem;
    logic                      w_div_zero;

    assign load_ready = (r_state != DIVIDE);
    assign w_accept   = load_en && load_ready;
    assign w_is_div   = (opcode == DIV) || (opcode == MOD);

    always_comb begin
        w_state_nxt = r_state;
        w_wb_en     = 1'b0;
        case (r_state)
            IDLE, EXEC: begin
                w_wb_en = (r_state == EXEC);
                if (w_accept) begin
                    w_state_nxt = w_is_div ? DIVIDE : EXEC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DIVIDE: begin
                if (r_cnt == '0) begin
                    w_wb_en     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_opc   <= ZERO;
            r_a     <= '0;
            r_b     <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_opc <= opcode;
                r_a   <= operand_a;
                r_b   <= operand_b;
                r_ptr <= write_pointer;
                r_cnt <= c_CNT_W'(DIV_LAT - 1);
            end else if (r_state == DIVIDE && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    instr_register_alu #(
        .OP_W  (OP_W),
        .RES_W (c_RES_W)
    ) u_alu (
        .i_opc (r_opc),
        .i_a   (r_a),
        .i_b   (r_b),
        .o_res (w_alu_res)
    );

    // Divide at full result width so MIN/-1 cannot overflow; a zero divisor
    // is swapped for 1 to keep the divider defined, the result is masked below.
    assign w_a_ext    = r_a;
    assign w_b_ext    = r_b;
    assign w_div_zero = (r_b == '0);
    assign w_b_safe   = w_div_zero ? c_RES_W'(1) : w_b_ext;
    assign w_quot     = w_a_ext / w_b_safe;
    assign w_rem      = w_a_ext % w_b_safe;

    always_comb begin
        w_wb_entry.opc   = r_opc;
        w_wb_entry.op_a  = r_a;
        w_wb_entry.op_b  = r_b;
        w_wb_entry.res   = w_alu_res;
        w_wb_entry.valid = 1'b1;
        w_wb_entry.err   = 1'b0;
        if (r_opc == DIV || r_opc == MOD) begin
            w_wb_entry.err = w_div_zero;
            if (w_div_zero) begin
                w_wb_entry.res = '0;
            end else begin
                w_wb_entry.res = (r_opc == DIV) ? w_quot : w_rem;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            instruction_word <= '0;
        end else begin
            if (w_wb_en) begin
                r_mem[r_ptr] <= w_wb_entry;
            end
            instruction_word <= (w_wb_en && r_ptr == read_pointer) ? w_wb_entry
                                                                    : r_mem[read_pointer];
        end
    end

`ifdef INSTR_REG_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accept_count   <= '0;
            div_zero_count <= '0;
        end else begin
            if (w_accept && accept_count != '1) begin
                accept_count <= accept_count + 1'b1;
            end
            if (w_wb_en && w_wb_entry.err && div_zero_count != '1) begin
                div_zero_count <= div_zero_count + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_register_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_register_exec
// Description : Directed self-checking bench with an expected-entry queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_register_exec;
    import instr_register_pkg::*;

    localparam int DEPTH = 32;
    localparam int OP_W  = 32;
    localparam int RES_W = 64;
    localparam int EW    = 3 + 2*OP_W + RES_W + 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   load_en = 1'b0;
    logic                   load_ready;
    opcode_t                opcode = ZERO;
    logic signed [OP_W-1:0] operand_a = '0;
    logic signed [OP_W-1:0] operand_b = '0;
    logic [4:0]             write_pointer = '0;
    logic [4:0]             read_pointer = '0;
    logic [EW-1:0]          instruction_word;
`ifdef INSTR_REG_STATS_EN
    logic [15:0]            accept_count;
    logic [7:0]             div_zero_count;
`endif

    instr_register_exec #(.DEPTH(DEPTH), .OP_W(OP_W), .DIV_LAT(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .load_en          (load_en),
        .load_ready       (load_ready),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .write_pointer    (write_pointer),
        .read_pointer     (read_pointer),
`ifdef INSTR_REG_STATS_EN
        .accept_count     (accept_count),
        .div_zero_count   (div_zero_count),
`endif
        .instruction_word (instruction_word)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    ptr;
        logic [EW-1:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_acc    = 0;

    function automatic logic [EW-1:0] model(opcode_t op, int a, int b);
        longint ae = a;
        longint be = b;
        longint res = 0;
        logic   err = 1'b0;
        case (op)
            ZERO:  res = 0;
            PASSA: res = ae;
            PASSB: res = be;
            ADD:   res = ae + be;
            SUB:   res = ae - be;
            MULT:  res = ae * be;
            DIV:   if (be == 0) err = 1'b1; else res = ae / be;
            MOD:   if (be == 0) err = 1'b1; else res = ae % be;
            default: res = 0;
        endcase
        return {op, a, b, res, 1'b1, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [EW-1:0] obs, logic [EW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_accept(opcode_t op, int a, int b, logic [4:0] p, bit push);
        load_en       = 1'b1;
        opcode        = op;
        operand_a     = a;
        operand_b     = b;
        write_pointer = p;
        chk("ready_at_accept", EW'(load_ready), EW'(1));
        tick();
        load_en = 1'b0;
        n_acc++;
        if (push) sb.push_back('{p, model(op, a, b)});
    endtask

    task automatic read_check(string tag);
        sb_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, EW'(0), EW'(1));
        end else begin
            e = sb.pop_front();
            read_pointer = e.ptr;
            tick();
            chk(tag, instruction_word, e.exp);
        end
    endtask

    task automatic stall_check(int n, string tag);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_low"}, EW'(load_ready), EW'(0));
            tick();
        end
        chk({tag, "_release"}, EW'(load_ready), EW'(1));
    endtask

    initial begin
        // Reset and blank read-back
        reset = 1'b1;
        repeat (3) tick();
        chk("iw_in_reset", instruction_word, EW'(0));
        reset = 1'b0;
        chk("ready_after_reset", EW'(load_ready), EW'(1));
        for (int i = 0; i < DEPTH; i++) begin
            read_pointer = 5'(i);
            tick();
            chk("reset_entry", instruction_word, EW'(0));
            chk("ready_idle", EW'(load_ready), EW'(1));
        end

        // Back-to-back single-cycle ops
        do_accept(ADD,  7, -3, 5'd0, 1'b1);
        do_accept(SUB,  5,  9, 5'd1, 1'b1);
        do_accept(MULT, -4, 6, 5'd2, 1'b1);
        chk("ready_after_b2b", EW'(load_ready), EW'(1));
        read_check("add_res");
        read_check("sub_res");
        read_check("mult_res");

        // DIV/MOD stall; a request during the stall is dropped
        do_accept(DIV, -17, 5, 5'd3, 1'b1);
        load_en       = 1'b1;
        opcode        = ADD;
        operand_a     = 1;
        operand_b     = 2;
        write_pointer = 5'd8;
        stall_check(4, "div_stall");
        load_en = 1'b0;
        do_accept(MOD, -17, 5, 5'd4, 1'b1);
        stall_check(4, "mod_stall");
        read_check("div_res");
        read_check("mod_res");
        read_pointer = 5'd8;
        tick();
        chk("dropped_no_write", instruction_word, EW'(0));

        // Divide by zero
        do_accept(DIV, 9, 0, 5'd5, 1'b1);
        stall_check(4, "divz_stall");
        read_check("divz_res");
`ifdef INSTR_REG_STATS_EN
        chk("div_zero_count", EW'(div_zero_count), EW'(1));
        chk("accept_count", EW'(accept_count), EW'(n_acc));
`endif

        // Other single-cycle ops, including top pointer
        do_accept(PASSA, -5, 3, 5'd31, 1'b1);
        do_accept(PASSB, -5, 3, 5'd30, 1'b1);
        do_accept(ZERO, 12, 34, 5'd29, 1'b1);
        read_check("passa_res");
        read_check("passb_res");
        read_check("zero_res");

        // Reset during an in-flight divide discards it
        do_accept(DIV, 50, 7, 5'd6, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("ready_async_reset", EW'(load_ready), EW'(1));
        chk("iw_async_reset", instruction_word, EW'(0));
        sb.delete();
        n_acc = 0;
        tick();
        reset = 1'b0;
        read_pointer = 5'd6;
        repeat (3) tick();
        chk("discarded_div", instruction_word, EW'(0));
`ifdef INSTR_REG_STATS_EN
        chk("accept_count_reset", EW'(accept_count), EW'(0));
        chk("div_zero_count_reset", EW'(div_zero_count), EW'(0));
`endif
        do_accept(ADD, 1, 1, 5'd6, 1'b1);
        read_check("add_after_reset");

        // Write-first bypass on the held read pointer
        read_pointer = 5'd7;
        tick();
        chk("stale_before", instruction_word, EW'(0));
        do_accept(ADD, 100, -1, 5'd7, 1'b1);
        chk("stale_at_accept", instruction_word, EW'(0));
        read_check("bypass_res");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_register_exec.md
Name: instr_register_exec

Overview:
Parametrised next-generation instruction register. Stores {opcode, operand_a, operand_b} per location and computes and stores the result through an execute stage. Simple ops run at one instruction per cycle; DIV/MOD are multi-cycle with a ready/stall handshake. Sits between the stimulus/driver side and the read-back/checker side of the lab DUT.

Parameters:
DEPTH, 32, number of register locations (power of 2, >=2)
OP_W, 32, signed operand width; result width RES_W = 2*OP_W
DIV_LAT, 4, cycles DIV/MOD occupy the execute stage (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
load_en  in  1  write request
load_ready  out  1  request accepted when load_en && load_ready at posedge
opcode  in  3  opcode_t: ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD (0..7)
operand_a  in  OP_W  signed
operand_b  in  OP_W  signed
write_pointer  in  $clog2(DEPTH)  destination location
read_pointer  in  $clog2(DEPTH)  read location
instruction_word  out  entry  registered read data {opc, op_a, op_b, res[RES_W], valid, err}

Behaviour:
- Reset (async, any time): all entries zero (valid=0, err=0); instruction_word=0; FSM to IDLE; load_ready=1; an in-flight operation is discarded and never written.
- FSM states IDLE, EXEC, DIVIDE; Moore output load_ready = (state != DIVIDE).
- Accept at edge T: latch opcode, operands and pointer into execute regs. DIV/MOD -> DIVIDE with cnt=DIV_LAT-1; other ops -> EXEC.
- EXEC: result written to mem[ptr] at edge T+1 with valid=1. A new accept at the same edge is allowed (back-to-back). Without an accept, go to IDLE.
- DIVIDE: cnt decrements each cycle. At edge T+DIV_LAT, entry written and state -> IDLE, so load_ready is low for exactly DIV_LAT cycles. load_en while not ready is ignored and does not stall or queue.
- Arithmetic: all ops are sign-extended to RES_W. ZERO=0; PASSA=op_a; PASSB=op_b; ADD/SUB are exact (no overflow); MULT is the full signed product; DIV truncates toward zero; MOD takes the dividend's sign. A divisor of 0 gives res=0 and err=1; all other cases give err=0.
- Overwriting a location replaces all fields.
- Read: instruction_word <= mem[read_pointer] each edge, so latency is 1 cycle. Write-first bypass: if a writeback targets read_pointer at the same edge, the new entry is returned.
- Pointers wrap naturally at DEPTH because the width is exact.

Optional Feature:
INSTR_REG_STATS_EN
- Defined: extra outputs accept_count[15:0] (accepted requests) and div_zero_count[7:0]. Both saturate at all-ones and clear on reset.
- Undefined: ports and counters absent. Functional behaviour is otherwise identical.

Decomposition:
- instr_register_pkg: opcode_t enum, state enum, default-width localparams, and a function returning RES_W from OP_W.
- Entry struct: declared in the module (parametrised widths).
- One sub-module, instr_register_alu: purely combinational result for ZERO..MULT. The DIV/MOD latency counter and divide-by-zero check stay in the top.

Test Plan:
1. Reset for 3 cycles, then read 0..31 -> all fields 0, valid=0; load_ready=1 throughout after reset.
2. Back-to-back accepts on consecutive cycles: ADD 7,-3 @0; SUB 5,9 @1; MULT -4,6 @2 -> load_ready stays 1; res 4, -4, -24; each valid=1 readable 2 edges after its accept.
3. DIV -17,5 @3 then MOD -17,5 @4 (DIV_LAT=4) -> load_ready low 4 cycles after each accept; res -3 and -2; load_en asserted while stalled is dropped, with no write to its pointer.
4. DIV 9,0 @5 -> res=0, err=1, valid=1; with INSTR_REG_STATS_EN, div_zero_count=1.
5. Accept DIV @6, assert reset 2 cycles later -> entry 6 remains zero/invalid; load_ready=1 immediately; the next ADD 1,1 @6 completes with res=2.
6. read_pointer=7 held while ADD 100,-1 @7 writes back -> instruction_word shows res=99, valid=1 at the writeback edge (bypass), not the stale zero entry.
